// File: rtl/ysyx_24100029_pkg.sv
// Shared constants for the write-back unit: default widths, load funct3 codes, buffer state.
package ysyx_24100029_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } wbu_state_e;

endpackage

// File: rtl/ysyx_24100029_load_ext.sv
// Combinational load formatter: lane select, sign/zero extension and misalignment detection.
module ysyx_24100029_load_ext
    import ysyx_24100029_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  is_load_i,
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            addr_lo_i,
    input  logic [DATA_WIDTH-1:0] alu_result_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = mem_rdata_i[7:0];
            2'd1: byte_sel = mem_rdata_i[15:8];
            2'd2: byte_sel = mem_rdata_i[23:16];
            2'd3: byte_sel = mem_rdata_i[31:24];
            default: byte_sel = mem_rdata_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    end

    always_comb begin
        data_o     = alu_result_i;
        misalign_o = 1'b0;
        if (is_load_i) begin
            case (funct3_i)
                F3_LB:  data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
                F3_LBU: data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
                F3_LH: begin
                    data_o     = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
                    misalign_o = addr_lo_i[0];
                end
                F3_LHU: begin
                    data_o     = {{(DATA_WIDTH-16){1'b0}}, half_sel};
                    misalign_o = addr_lo_i[0];
                end
                // lw and any undefined encoding: full word, must be word aligned
                default: begin
                    data_o     = mem_rdata_i;
                    misalign_o = (addr_lo_i != 2'b00);
                end
            endcase
        end
    end

endmodule

// File: rtl/ysyx_24100029_wbu.sv
// Write-back unit: one-entry result buffer between LSU and register file with bypass.
// Optional retire counter / commit pc enabled by YSYX_24100029_WBU_RETIRE_CNT_EN.
module ysyx_24100029_wbu
    import ysyx_24100029_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_addr_lo,
    input  logic [DATA_WIDTH-1:0] in_alu_result,
    input  logic [DATA_WIDTH-1:0] in_mem_rdata,
`ifdef YSYX_24100029_WBU_RETIRE_CNT_EN
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic [DATA_WIDTH-1:0] commit_pc,
    output logic [63:0]           retire_cnt,
`endif
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wen,
    output logic                  commit_valid,
    input  logic                  commit_ready,
    output logic                  misalign,
    output logic                  fwd_valid,
    output logic [ADDR_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    wbu_state_e            state_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  rd_wen_q;
    logic                  mis_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  mis_d;

    logic full;
    logic in_fire;
    logic commit_fire;
    logic writes;

    ysyx_24100029_load_ext #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_ext (
        .is_load_i    (in_is_load),
        .funct3_i     (in_funct3),
        .addr_lo_i    (in_addr_lo),
        .alu_result_i (in_alu_result),
        .mem_rdata_i  (in_mem_rdata),
        .data_o       (data_d),
        .misalign_o   (mis_d)
    );

    assign full        = (state_q == ST_FULL);
    assign commit_fire = full && commit_ready;
    assign in_ready    = !full || commit_fire;
    assign in_fire     = in_valid && in_ready;
    // A buffered entry is architecturally visible only if it targets a real register cleanly
    assign writes      = full && rd_wen_q && (rd_q != '0) && !mis_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_EMPTY;
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
            mis_q    <= 1'b0;
            data_q   <= '0;
        end else if (in_fire) begin
            state_q  <= ST_FULL;
            rd_q     <= in_rd;
            rd_wen_q <= in_rd_wen;
            mis_q    <= mis_d;
            data_q   <= data_d;
        end else if (commit_fire) begin
            state_q  <= ST_EMPTY;
        end
    end

    assign commit_valid = full;
    assign misalign     = full && mis_q;
    assign wen          = writes && commit_ready;
    assign waddr        = full ? rd_q : '0;
    assign wdata        = full ? data_q : '0;
    assign fwd_valid    = writes;
    assign fwd_rd       = full ? rd_q : '0;
    assign fwd_data     = full ? data_q : '0;

`ifdef YSYX_24100029_WBU_RETIRE_CNT_EN
    logic [DATA_WIDTH-1:0] pc_q;
    logic [63:0]           cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (in_fire) begin
                pc_q <= in_pc;
            end
            if (commit_fire) begin
                cnt_q <= cnt_q + 64'd1;
            end
        end
    end

    assign commit_pc  = full ? pc_q : '0;
    assign retire_cnt = cnt_q;
`endif

endmodule

// File: doc/ysyx_24100029_wbu.md
YSYX_24100029_WBU -- requirements
Module: ysyx_24100029_wbu

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-003 SHALL have port clock  in  1  sole clock; all state on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (low = reset).
REQ-005 SHALL have ports in_valid in 1 and in_ready out 1, the upstream (LSU) handshake.
REQ-006 SHALL have port in_rd  in  ADDR_WIDTH  destination register.
REQ-007 SHALL have port in_rd_wen  in  1  instruction writes rd.
REQ-008 SHALL have port in_is_load  in  1  result comes from memory.
REQ-009 SHALL have port in_funct3  in  3  load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-010 SHALL have port in_addr_lo  in  2  load address bits [1:0].
REQ-011 SHALL have ports in_alu_result and in_mem_rdata, each in DATA_WIDTH, carrying the ALU result and the raw aligned memory word.
REQ-012 SHALL have ports wdata out DATA_WIDTH, waddr out ADDR_WIDTH and wen out 1, the register-file write port.
REQ-013 SHALL have ports commit_valid out 1 and commit_ready in 1, the retire handshake.
REQ-014 SHALL have port misalign  out  1  valid with commit_valid; buffered load is misaligned.
REQ-015 SHALL have ports fwd_valid out 1, fwd_rd out ADDR_WIDTH and fwd_data out DATA_WIDTH, a bypass of the buffered result.

Function
REQ-016 SHALL hold a one-entry buffer with state EMPTY/FULL; an input fire is in_valid&&in_ready, a commit fire is commit_valid&&commit_ready.
REQ-017 SHALL drive in_ready = EMPTY || commit fire, so back-to-back throughput is one instruction per cycle.
REQ-018 SHALL transition EMPTY->FULL on an input fire, FULL->EMPTY on a commit without an input fire, and stay FULL when both fire in the same cycle, loading the new entry.
REQ-019 SHALL format load data at input acceptance: lb/lbu select byte addr_lo and sign/zero-extend; lh/lhu select half addr_lo[1] and sign/zero-extend; lw passes the word; a non-load takes in_alu_result.
REQ-020 SHALL flag misalign for lh/lhu with addr_lo[0]=1 and for lw with addr_lo!=0; a misaligned entry still commits but never writes.
REQ-021 SHALL drive commit_valid = FULL.
REQ-022 SHALL assert wen only in a commit-fire cycle, with rd_wen=1, rd!=0 and misalign=0, so the register file updates at the edge closing the handshake.
REQ-023 SHALL give latency from input fire at edge N to register write at edge N+1 at minimum; each stalled commit_ready cycle adds one cycle.
REQ-024 SHALL drive waddr/wdata from the buffer whenever FULL and zero when EMPTY.
REQ-025 SHALL assert fwd_valid = FULL && rd_wen && rd!=0 && !misalign, with fwd_rd/fwd_data taken from the buffer.
REQ-026 SHALL treat an undefined funct3 on a load as lw.

Reset
REQ-027 SHALL, while reset is low, force EMPTY and clear the buffer, and every output: in_ready=1, commit_valid=0, wen=0, misalign=0, fwd_valid=0, all data/address outputs 0.
REQ-028 SHALL discard a buffered, uncommitted entry when reset is asserted mid-operation, with no register write.

Configuration
REQ-029 SHALL, with YSYX_24100029_WBU_RETIRE_CNT_EN defined, add port in_pc in DATA_WIDTH, port commit_pc out DATA_WIDTH (the buffered pc) and port retire_cnt out 64 (incremented on every commit fire, reset 0, wraps to 0 after all-ones).
REQ-030 SHALL, without that macro, omit those ports and the counter entirely.

Structure
REQ-031 SHALL place the funct3 load encodings and the default ADDR_WIDTH/DATA_WIDTH constants in the shared package ysyx_24100029_pkg.
REQ-032 SHALL implement the load formatting as sub-module ysyx_24100029_load_ext (combinational).

Verification
REQ-033 SHALL cover: lb, addr_lo=3, mem_rdata=0x80FF_0000 -> wdata=0xFFFF_FF80 at the first commit.
REQ-034 SHALL cover: lhu, addr_lo=2, mem_rdata=0x9ABC_1234 -> wdata=0x0000_9ABC.
REQ-035 SHALL cover: commit_ready low for 3 cycles with a second input pending -> in_ready=0, wen=0 throughout; both entries write in order after release.
REQ-036 SHALL cover: rd=0 with rd_wen=1 -> commit fires, wen=0, fwd_valid=0.
REQ-037 SHALL cover: lw, addr_lo=1 -> misalign=1, commit fires, wen=0.
REQ-038 SHALL cover: reset low while FULL -> wen never asserts and commit_valid=0 immediately; in_ready=1 after release.
